// File: rtl/mci_reg_arbiter.sv
// Round-robin N-requester arbiter driving the single MCI master port, one transaction in flight.
// Adds an ack timeout that completes the transaction with an error pulse and all-ones read data.
module mci_reg_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic [NUM_REQ-1:0]                          i_req_request,
    input  logic [NUM_REQ*ADDR_W-1:0]                   i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]                   i_req_wr_data,
    input  logic [NUM_REQ-1:0]                          i_req_rdwn,
    output logic [NUM_REQ-1:0]                          o_req_done,
    output logic [NUM_REQ-1:0]                          o_req_err,
    output logic [DATA_W-1:0]                           o_req_rd_data,
    output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] o_grant_id,
    output logic                                        o_busy,
    output logic                                        o_mci_val,
    output logic [DATA_W-1:0]                           o_mci_wdata,
    output logic [DATA_W/8-1:0]                         o_mci_be,
    output logic [ADDR_W-1:0]                           o_mci_addr,
    output logic                                        o_mci_rdwn,
    input  logic                                        i_mci_ack,
    input  logic [DATA_W-1:0]                           i_mci_rdata
);

    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GID_W-1:0]    grant_q, grant_d;
    logic [GID_W-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                mci_val_q, mci_val_d;
    logic [DATA_W-1:0]   mci_wdata_q, mci_wdata_d;
    logic [BE_W-1:0]     mci_be_q;
    logic [ADDR_W-1:0]   mci_addr_q, mci_addr_d;
    logic                mci_rdwn_q, mci_rdwn_d;
    logic [NUM_REQ-1:0]  req_done_q, req_done_d;
    logic [NUM_REQ-1:0]  req_err_q, req_err_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic                any_req;
    logic                hi_found;
    logic [GID_W-1:0]    hi_idx, lo_idx, winner;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_rdwn;
    logic [NUM_REQ-1:0]  grant_oh;

    // Descending scan: last hit is the lowest set index; hi_* only counts indices above last_grant.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_request[i]) begin
                lo_idx = GID_W'(i);
                if (i > int'(last_grant_q)) begin
                    hi_idx   = GID_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        any_req = |i_req_request;
        winner  = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rdwn  = 1'b0;
        grant_oh  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GID_W'(i) == winner) begin
                sel_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = i_req_wr_data[i*DATA_W +: DATA_W];
                sel_rdwn  = i_req_rdwn[i];
            end
            grant_oh[i] = (GID_W'(i) == grant_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mci_val_d    = mci_val_q;
        mci_wdata_d  = mci_wdata_q;
        mci_addr_d   = mci_addr_q;
        mci_rdwn_d   = mci_rdwn_q;
        req_done_d   = '0;
        req_err_d    = '0;
        rd_data_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d     = winner;
                    mci_addr_d  = sel_addr;
                    mci_wdata_d = sel_wdata;
                    mci_rdwn_d  = sel_rdwn;
                    mci_val_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (i_mci_ack) begin
                    mci_val_d  = 1'b0;
                    rd_data_d  = mci_rdwn_q ? i_mci_rdata : '0;
                    req_done_d = grant_oh;
                    state_d    = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    mci_val_d  = 1'b0;
                    rd_data_d  = '1;
                    req_done_d = grant_oh;
                    req_err_d  = grant_oh;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GID_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            mci_val_q    <= 1'b0;
            mci_wdata_q  <= '0;
            mci_be_q     <= '1;
            mci_addr_q   <= '0;
            mci_rdwn_q   <= 1'b0;
            req_done_q   <= '0;
            req_err_q    <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            mci_val_q    <= mci_val_d;
            mci_wdata_q  <= mci_wdata_d;
            mci_be_q     <= '1;
            mci_addr_q   <= mci_addr_d;
            mci_rdwn_q   <= mci_rdwn_d;
            req_done_q   <= req_done_d;
            req_err_q    <= req_err_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign o_req_done    = req_done_q;
    assign o_req_err     = req_err_q;
    assign o_req_rd_data = rd_data_q;
    assign o_grant_id    = grant_q;
    assign o_busy        = busy_q;
    assign o_mci_val     = mci_val_q;
    assign o_mci_wdata   = mci_wdata_q;
    assign o_mci_be      = mci_be_q;
    assign o_mci_addr    = mci_addr_q;
    assign o_mci_rdwn    = mci_rdwn_q;

endmodule

// File: tb/tb_mci_reg_arbiter.sv
// Self-checking bench for mci_reg_arbiter: directed scenarios plus randomized traffic against a round-robin model.
module tb_mci_reg_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 14;
    localparam int DW   = 32;
    localparam int TO   = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdat;
    logic [NREQ-1:0]   rdwn;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   rerr;
    logic [DW-1:0]     rd;
    logic [1:0]        gid;
    logic              busy;
    logic              val;
    logic [DW-1:0]     mwdata;
    logic [DW/8-1:0]   be;
    logic [AW-1:0]     maddr;
    logic              mrdwn;
    logic              ack;
    logic [DW-1:0]     rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mci_reg_arbiter #(
        .NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_request(req), .i_req_addr(addr), .i_req_wr_data(wdat), .i_req_rdwn(rdwn),
        .o_req_done(done), .o_req_err(rerr), .o_req_rd_data(rd),
        .o_grant_id(gid), .o_busy(busy),
        .o_mci_val(val), .o_mci_wdata(mwdata), .o_mci_be(be), .o_mci_addr(maddr),
        .o_mci_rdwn(mrdwn), .i_mci_ack(ack), .i_mci_rdata(rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; addr = '0; wdat = '0; rdwn = '0; ack = 1'b0; rdata = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic rd_n, input logic on);
        addr[k*AW +: AW] = a;
        wdat[k*DW +: DW] = d;
        rdwn[k]          = rd_n;
        req[k]           = on;
    endtask

    task automatic wait_val(input string name);
        int n = 0;
        while (!val && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (val !== 1'b1) begin
            errors++;
            $display("FAIL %s_val_timeout: o_mci_val=%b after %0d cycles, required 1", name, val, n);
        end
    endtask

    // Reference arbitration: first active index searching upward from last+1 modulo NREQ.
    function automatic int rr_pick(input int last, input logic [NREQ-1:0] act);
        for (int k = 1; k <= NREQ; k++) begin
            if (act[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic test_reset();
        req = '0; addr = '0; wdat = '0; rdwn = '0; ack = 1'b0; rdata = '0;
        rst = 1'b1;
        tick();
        checks++; if (val !== 1'b0)   begin errors++; $display("FAIL reset_val: got %b want 0", val); end
        checks++; if (be !== 4'hF)    begin errors++; $display("FAIL reset_be: got %h want f", be); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== '0 || rerr !== '0 || rd !== '0)
            begin errors++; $display("FAIL reset_done: done=%b err=%b rd=%h want 0", done, rerr, rd); end
        checks++; if (gid !== 2'd0 || maddr !== '0 || mwdata !== '0 || mrdwn !== 1'b0)
            begin errors++; $display("FAIL reset_mci: gid=%0d addr=%h wdata=%h rdwn=%b want 0", gid, maddr, mwdata, mrdwn); end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || val !== 1'b0)
            begin errors++; $display("FAIL reset_idle: busy=%b val=%b want 0", busy, val); end
    endtask

    task automatic test_read();
        int nval = 0;
        do_reset();
        set_req(0, 14'h0010, 32'h0, 1'b1, 1'b1);
        tick();
        checks++; if (val !== 1'b1 || maddr !== 14'h0010 || mrdwn !== 1'b1 || be !== 4'hF)
            begin errors++; $display("FAIL read_issue: val=%b addr=%h rdwn=%b be=%h want 1/0010/1/f", val, maddr, mrdwn, be); end
        for (int c = 1; c <= 3; c++) begin
            if (val) nval++;
            if (c == 3) begin ack = 1'b1; rdata = 32'h1234_5678; end
            tick();
        end
        ack = 1'b0;
        checks++; if (nval != 3 || val !== 1'b0)
            begin errors++; $display("FAIL read_val_len: high %0d cycles val=%b want 3/0", nval, val); end
        checks++; if (done !== 3'b001 || rerr !== 3'b000 || rd !== 32'h1234_5678)
            begin errors++; $display("FAIL read_done: done=%b err=%b rd=%h want 001/000/12345678", done, rerr, rd); end
        req[0] = 1'b0;
        tick();
        checks++; if (done !== '0 || rd !== '0)
            begin errors++; $display("FAIL read_done_clear: done=%b rd=%h want 0", done, rd); end
    endtask

    task automatic test_round_robin();
        logic [1:0] expg;
        do_reset();
        set_req(0, 14'h00A1, 32'h0, 1'b1, 1'b1);
        set_req(1, 14'h01B2, 32'h0, 1'b1, 1'b1);
        for (int t = 0; t < 4; t++) begin
            expg = 2'(t % 2);
            wait_val("rr");
            checks++; if (gid !== expg || maddr !== addr[expg*AW +: AW])
                begin errors++; $display("FAIL rr_grant%0d: gid=%0d addr=%h want %0d/%h", t, gid, maddr, expg, addr[expg*AW +: AW]); end
            ack = 1'b1; rdata = 32'(t);
            tick();
            ack = 1'b0;
            checks++; if (done !== 3'(1 << expg))
                begin errors++; $display("FAIL rr_done%0d: done=%b want %b", t, done, 3'(1 << expg)); end
            if (t == 3) req = '0;
            tick();
        end
    endtask

    task automatic test_timeout();
        int nval = 0;
        do_reset();
        set_req(1, 14'h0200, 32'hA5A5_A5A5, 1'b0, 1'b1);
        tick();
        checks++; if (val !== 1'b1 || maddr !== 14'h0200 || mwdata !== 32'hA5A5_A5A5 || mrdwn !== 1'b0 || gid !== 2'd1)
            begin errors++; $display("FAIL to_issue: val=%b addr=%h wdata=%h rdwn=%b gid=%0d", val, maddr, mwdata, mrdwn, gid); end
        while (val && nval < 400) begin
            nval++;
            tick();
        end
        checks++; if (nval != TO)
            begin errors++; $display("FAIL to_val_len: high %0d cycles want %0d", nval, TO); end
        checks++; if (done !== 3'b010 || rerr !== 3'b010 || rd !== 32'hFFFF_FFFF)
            begin errors++; $display("FAIL to_done: done=%b err=%b rd=%h want 010/010/ffffffff", done, rerr, rd); end
        req = '0;
        tick();
        checks++; if (done !== '0 || rerr !== '0 || busy !== 1'b0)
            begin errors++; $display("FAIL to_clear: done=%b err=%b busy=%b want 0", done, rerr, busy); end
    endtask

    task automatic test_ack_at_limit();
        int nval = 0;
        do_reset();
        set_req(0, 14'h0033, 32'h0, 1'b1, 1'b1);
        tick();
        for (int c = 1; c <= TO; c++) begin
            if (val) nval++;
            if (c == TO) begin ack = 1'b1; rdata = 32'hCAFE_F00D; end
            tick();
        end
        ack = 1'b0;
        checks++; if (nval != TO)
            begin errors++; $display("FAIL limit_val_len: high %0d cycles want %0d", nval, TO); end
        checks++; if (done !== 3'b001 || rerr !== 3'b000 || rd !== 32'hCAFE_F00D)
            begin errors++; $display("FAIL limit_done: done=%b err=%b rd=%h want 001/000/cafef00d", done, rerr, rd); end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic saw_done = 1'b0;
        do_reset();
        set_req(0, 14'h0044, 32'h0, 1'b1, 1'b1);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (val !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL rst_async: val=%b busy=%b want 0", val, busy); end
        req = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done !== '0) saw_done = 1'b1;
        end
        rst = 1'b0;
        tick();
        if (done !== '0) saw_done = 1'b1;
        checks++; if (saw_done)
            begin errors++; $display("FAIL rst_no_done: done pulse seen after reset, want none"); end
        set_req(1, 14'h0155, 32'h1122_3344, 1'b0, 1'b1);
        tick();
        checks++; if (val !== 1'b1 || gid !== 2'd1 || be !== 4'hF || maddr !== 14'h0155)
            begin errors++; $display("FAIL rst_next: val=%b gid=%0d be=%h addr=%h want 1/1/f/0155", val, gid, be, maddr); end
        ack = 1'b1; rdata = 32'h5555_5555;
        tick();
        ack = 1'b0;
        checks++; if (done !== 3'b010 || rerr !== '0 || rd !== '0)
            begin errors++; $display("FAIL rst_next_done: done=%b err=%b rd=%h want 010/000/0", done, rerr, rd); end
        req = '0;
        tick();
    endtask

    task automatic test_stray_ack();
        do_reset();
        ack = 1'b1; rdata = 32'hFFFF_0000;
        tick();
        ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++; if (done !== '0 || rerr !== '0 || busy !== 1'b0 || val !== 1'b0)
                begin errors++; $display("FAIL stray_ack%0d: done=%b err=%b busy=%b val=%b want 0", c, done, rerr, busy, val); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] act = '0;
        int              last = NREQ - 1;
        int              exp;
        int              dly;
        logic [1:0]      expg;
        logic [DW-1:0]   rv;
        logic [DW-1:0]   exp_rd;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!act[k] && $urandom_range(0, 1) == 1) begin
                    set_req(k, AW'($urandom), $urandom, 1'($urandom), 1'b1);
                    act[k] = 1'b1;
                end
            end
            if (act == '0) begin
                exp = $urandom_range(0, NREQ - 1);
                set_req(exp, AW'($urandom), $urandom, 1'($urandom), 1'b1);
                act[exp] = 1'b1;
            end
            wait_val("rand");
            exp  = rr_pick(last, act);
            expg = 2'(exp);
            checks++; if (gid !== expg || maddr !== addr[exp*AW +: AW] || mrdwn !== rdwn[exp] ||
                          (!rdwn[exp] && mwdata !== wdat[exp*DW +: DW]) || busy !== 1'b1)
                begin errors++; $display("FAIL rand_issue%0d: gid=%0d addr=%h rdwn=%b busy=%b want gid %0d addr %h", t, gid, maddr, mrdwn, busy, exp, addr[exp*AW +: AW]); end
            dly = $urandom_range(0, 4);
            for (int d = 0; d < dly; d++) tick();
            rv = $urandom;
            ack = 1'b1; rdata = rv;
            tick();
            ack = 1'b0;
            exp_rd = rdwn[exp] ? rv : '0;
            checks++; if (done !== 3'(1 << exp) || rerr !== '0 || rd !== exp_rd)
                begin errors++; $display("FAIL rand_done%0d: done=%b err=%b rd=%h want %b/000/%h", t, done, rerr, rd, 3'(1 << exp), exp_rd); end
            last = exp;
            act[exp] = 1'b0;
            req[exp] = 1'b0;
            tick();
        end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_round_robin();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        test_stray_ack();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
